// File: rtl/gshare_bht_pkg.sv
// Shared types for the gshare branch history table: the per-slot prediction
// payload and the flush walker states.
package gshare_bht_pkg;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_e;

endpackage

// File: rtl/gshare_sat_ctr.sv
// Saturating up/down direction counter: steps toward the resolved direction
// and sticks at both ends.
module gshare_sat_ctr #(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_i,
    input  logic                taken_i,
    output logic [CTR_BITS-1:0] ctr_o
);

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_MAX) ctr_o = ctr_i + CTR_BITS'(1);
        end else begin
            if (ctr_i != CTR_MIN) ctr_o = ctr_i - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/gshare_bht.sv
// Direction predictor: rows of saturating counters indexed by PC (optionally
// XORed with global history), speculative GHR with recovery, row-walk flush.
module gshare_bht
    import gshare_bht_pkg::*;
#(
    parameter int unsigned VLEN            = 64,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter bit          RVC             = 1'b1,
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned CTR_BITS        = 2,
    parameter int unsigned GHR_BITS        = 8,
    parameter bit          GSHARE          = 1'b1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     flush_bp_i,
    input  logic                                     debug_mode_i,
    input  logic [VLEN-1:0]                          vpc_i,
    input  logic                                     predict_valid_i,
    input  logic                                     predict_taken_i,
    input  logic                                     update_valid_i,
    input  logic [VLEN-1:0]                          update_pc_i,
    input  logic                                     update_taken_i,
    input  logic [GHR_BITS-1:0]                      update_ghr_i,
    input  logic                                     update_mispredict_i,
    output bht_prediction_t [INSTR_PER_FETCH-1:0]    bht_prediction_o,
    output logic [GHR_BITS-1:0]                      ghr_o,
    output logic                                     flush_busy_o
);

    localparam int unsigned OFFSET        = RVC ? 1 : 2;
    localparam int unsigned NR_ROWS       = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned ROW_BITS      = $clog2(NR_ROWS);
    localparam int unsigned ROW_ADDR_BITS = $clog2(INSTR_PER_FETCH);
    localparam int unsigned SLOT_W        = (ROW_ADDR_BITS > 0) ? ROW_ADDR_BITS : 1;
    localparam int unsigned ROW_LSB       = ROW_ADDR_BITS + OFFSET;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(NR_ROWS - 1);

    typedef struct packed {
        logic                valid;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    localparam entry_t ENTRY_INIT = '{valid: 1'b0, ctr: CTR_INIT};

    flush_state_e          state_q;
    logic [ROW_BITS-1:0]   row_cnt_q;
    logic [GHR_BITS-1:0]   ghr_q;
    entry_t                bht_q [NR_ROWS][INSTR_PER_FETCH];

    logic                  in_flush;
    logic [ROW_BITS-1:0]   prow;
    logic [ROW_BITS-1:0]   urow;
    logic [SLOT_W-1:0]     uslot;
    entry_t                upd_entry;
    logic [CTR_BITS-1:0]   upd_ctr;

    logic                       wr_en;
    logic [ROW_BITS-1:0]        wr_row;
    logic [INSTR_PER_FETCH-1:0] wr_mask;
    entry_t                     wr_data;

    logic                  unused_bits;

    assign in_flush     = (state_q == FLUSH);
    assign flush_busy_o = in_flush;
    assign ghr_o        = ghr_q;

    // Read row uses the live GHR; update row uses the snapshot taken at predict time.
    assign prow = vpc_i[ROW_BITS+ROW_LSB-1:ROW_LSB]
                ^ (GSHARE ? ROW_BITS'(ghr_q) : ROW_BITS'(0));
    assign urow = update_pc_i[ROW_BITS+ROW_LSB-1:ROW_LSB]
                ^ (GSHARE ? ROW_BITS'(update_ghr_i) : ROW_BITS'(0));

    if (RVC && (ROW_ADDR_BITS > 0)) begin : g_slot_pc
        assign uslot = update_pc_i[ROW_LSB-1:OFFSET];
    end else begin : g_slot_zero
        assign uslot = '0;
    end

    assign upd_entry = bht_q[urow][uslot];

    gshare_sat_ctr #(
        .CTR_BITS (CTR_BITS)
    ) i_sat_ctr (
        .ctr_i   (upd_entry.ctr),
        .taken_i (update_taken_i),
        .ctr_o   (upd_ctr)
    );

    // Prediction read port; blanked while the walk is clearing the table.
    always_comb begin
        bht_prediction_o = '0;
        if (!in_flush) begin
            for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
                bht_prediction_o[i].valid = bht_q[prow][i].valid;
                bht_prediction_o[i].taken = bht_q[prow][i].ctr[CTR_BITS-1];
            end
        end
    end

    // Single write port: the flush walk owns it, otherwise resolved updates.
    always_comb begin
        wr_en   = 1'b0;
        wr_row  = urow;
        wr_mask = '0;
        wr_data = '{valid: 1'b1, ctr: upd_ctr};
        if (!rst_i) begin
            if (in_flush) begin
                wr_en   = 1'b1;
                wr_row  = row_cnt_q;
                wr_mask = '1;
                wr_data = ENTRY_INIT;
            end else if (update_valid_i && !debug_mode_i) begin
                wr_en   = 1'b1;
                wr_mask = INSTR_PER_FETCH'(1) << uslot;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
                if (wr_mask[i]) bht_q[wr_row][i] <= wr_data;
            end
        end
    end

    // Flush walker: reset or a new request restarts from row 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= FLUSH;
            row_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush_bp_i) begin
                        state_q   <= FLUSH;
                        row_cnt_q <= '0;
                    end
                end
                FLUSH: begin
                    if (flush_bp_i) begin
                        row_cnt_q <= '0;
                    end else if (row_cnt_q == ROW_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        row_cnt_q <= row_cnt_q + ROW_BITS'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Mispredict recovery wins over a same-cycle speculative shift.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_bp_i) begin
            ghr_q <= '0;
        end else if (update_mispredict_i && update_valid_i) begin
            ghr_q <= {update_ghr_i[GHR_BITS-2:0], update_taken_i};
        end else if (predict_valid_i) begin
            ghr_q <= {ghr_q[GHR_BITS-2:0], predict_taken_i};
        end
    end

    assign unused_bits = ^{vpc_i, update_pc_i, update_ghr_i, upd_entry.valid};

endmodule
